ps2_keyboard: RTL
=================

# ps2_keyboard

Receives PS/2 scan-set-2 frames from an external keyboard and turns them into the 16-bit Hack key code that the Memory block's keyboard register (address 0x6000) presents to the CPU. It sits directly upstream of that register: its `out` replaces the constant keyboard value. It also tracks make/break and E0-prefix sequences, so `out` holds the code of the key currently pressed, or 0 when no key is pressed.

## Interface
- `TIMEOUT`, default 5000: clock cycles without a PS/2 falling edge before a partial frame is abandoned.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clock`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clock`.
- `out`  out  16  Hack key code of the held key; 0 when none is held.
- `key_strobe`  out  1  one-cycle pulse whenever `out` changes value.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped (framing error, parity error or timeout).

## Operation
- Synchronisation: `ps2_clk` and `ps2_data` each pass through 2 flops. A falling edge is detected when the synchronised clock was 1 last cycle and is 0 now. Data is sampled in the same cycle as the edge.
- Frame format, one bit per falling edge: start (0), 8 data bits LSB first, odd parity, stop (1).
- Receiver FSM states:
  - IDLE: an edge with data=0 goes to DATA; an edge with data=1 is ignored.
  - DATA: shift in bits, 3-bit counter. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: stop=1 with good parity delivers the byte to the decoder. Otherwise pulse `frame_err` and drop the byte. Either way, return to IDLE.
- Timeout: a cycle counter clears on every edge. In any state other than IDLE, if the counter reaches TIMEOUT, pulse `frame_err` and go to IDLE.
- Decoder, per delivered byte:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte is looked up (using `ext`), then both flags are cleared.
- Mapping (unmapped codes are ignored, but the flags are still cleared):
  - A–Z → 65–90; 0–9 → 48–57 (standard set-2 codes).
  - 0x29 space → 32; 0x5A enter → 128; 0x66 backspace → 129; 0x76 esc → 140.
  - E0 6B left → 130; E0 75 up → 131; E0 74 right → 132; E0 72 down → 133.
- Make of a mapped key sets `out` to its code; the last key pressed wins.
- Break of a key clears `out` to 0 only if it equals the current `out`. A break of any other key leaves `out` unchanged.
- A dropped frame or timeout clears `ext` and `brk` and leaves `out` unchanged.

## Timing
- Reset values: `out`=0, `key_strobe`=0, `frame_err`=0, FSM=IDLE, `ext`=`brk`=0, counters=0.
- Reset is asynchronous. Asserting it mid-frame discards the partial frame immediately. After deassertion, reception restarts from IDLE; the next start bit is honoured.
- Latency from the raw `ps2_clk` falling edge to edge detection: 2–3 clocks.
- `out` and `key_strobe` update on the clock edge after the cycle in which the stop-bit edge is detected.
- `frame_err` is asserted in that same cycle (for a dropped frame) or in the cycle after the timeout is reached.
- `key_strobe` pulses only when `out` changes. A repeated make (typematic) of the held key produces no strobe.
- The minimum supported `clock` is 8× the PS/2 clock (≥ ~130 kHz). Behaviour below that is undefined.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a frame with even parity is dropped and `frame_err` pulses.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is latched but ignored; only the stop bit and the timeout can drop a frame.

## Test plan
- Frame 0x1C (A) → `out`=65 and `key_strobe` high for exactly one cycle. Then F0,1C → `out`=0 with one strobe.
- E0,75 → `out`=131. Then F0,5A (a break of an unheld key) → `out` stays 131 with no strobe. Then E0,F0,75 → `out`=0.
- 0x1C with even parity: macro defined → `out` unchanged, one `frame_err` pulse; macro undefined → `out`=65.
- Start plus 4 data bits, then idle for TIMEOUT+1 cycles → one `frame_err` pulse. A following full 0x5A frame → `out`=128.
- Frame 0x5A with stop bit 0 → `frame_err` pulses, `out` unchanged. Next frame 0x45 → `out`=48.
- Assert `reset` low after the 5th data bit of 0x29, release it, send 0x29 → `out`=32. Also check `out`=0 while in reset.

Source files
------------

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 set-2 receiver and decoder producing the Hack keyboard register value (optional PS2_PARITY_CHECK_EN)
module ps2_keyboard #(
    parameter int TIMEOUT = 5000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] out,
    output logic        key_strobe,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    data_sr;
    logic          par_bit;
    logic [TW-1:0] idle_cnt;

    logic          ext;
    logic          brk;

    logic          timed_out;
    logic          parity_ok;
    logic          byte_ok;
    logic          drop;
    logic [15:0]   code;

    // Lookup of a completed scan code; zero means the key has no Hack code.
    function automatic logic [15:0] key_code(input logic e, input logic [7:0] sc);
        logic [15:0] c;
        c = 16'd0;
        if (e) begin
            case (sc)
                8'h6B:   c = 16'd130;
                8'h75:   c = 16'd131;
                8'h74:   c = 16'd132;
                8'h72:   c = 16'd133;
                default: c = 16'd0;
            endcase
        end else begin
            case (sc)
                8'h1C: c = 16'd65;  8'h32: c = 16'd66;  8'h21: c = 16'd67;
                8'h23: c = 16'd68;  8'h24: c = 16'd69;  8'h2B: c = 16'd70;
                8'h34: c = 16'd71;  8'h33: c = 16'd72;  8'h43: c = 16'd73;
                8'h3B: c = 16'd74;  8'h42: c = 16'd75;  8'h4B: c = 16'd76;
                8'h3A: c = 16'd77;  8'h31: c = 16'd78;  8'h44: c = 16'd79;
                8'h4D: c = 16'd80;  8'h15: c = 16'd81;  8'h2D: c = 16'd82;
                8'h1B: c = 16'd83;  8'h2C: c = 16'd84;  8'h3C: c = 16'd85;
                8'h2A: c = 16'd86;  8'h1D: c = 16'd87;  8'h22: c = 16'd88;
                8'h35: c = 16'd89;  8'h1A: c = 16'd90;
                8'h45: c = 16'd48;  8'h16: c = 16'd49;  8'h1E: c = 16'd50;
                8'h26: c = 16'd51;  8'h25: c = 16'd52;  8'h2E: c = 16'd53;
                8'h36: c = 16'd54;  8'h3D: c = 16'd55;  8'h3E: c = 16'd56;
                8'h46: c = 16'd57;
                8'h29: c = 16'd32;  8'h5A: c = 16'd128; 8'h66: c = 16'd129;
                8'h76: c = 16'd140;
                default: c = 16'd0;
            endcase
        end
        return c;
    endfunction

    // Two-flop synchronisers; reset to the idle-high line level so no false edge follows reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{data_sr, par_bit};
`else
    // Parity is still computed from the latched bit but never gates delivery.
    assign parity_ok = (^{data_sr, par_bit}) | 1'b1;
`endif

    assign timed_out = (state != S_IDLE) && !fall && (idle_cnt == TW'(TIMEOUT));
    assign byte_ok   = fall && (state == S_STOP) && bit_in && parity_ok;
    assign drop      = timed_out || (fall && (state == S_STOP) && !(bit_in && parity_ok));
    assign code      = key_code(ext, data_sr);

    // Cycles since the last PS/2 falling edge, saturating at the timeout value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (fall) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TW'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    // Frame receiver: start, eight data bits LSB first, parity, stop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            data_sr <= 8'd0;
            par_bit <= 1'b0;
        end else if (timed_out) begin
            state <= S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!bit_in) begin
                        state   <= S_DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                S_DATA: begin
                    data_sr <= {bit_in, data_sr[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_bit <= bit_in;
                    state   <= S_STOP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoder: prefix flags, make/break tracking of the held key, and the one-cycle pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out        <= 16'd0;
            key_strobe <= 1'b0;
            frame_err  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            frame_err  <= drop;
            if (drop) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_ok) begin
                if (data_sr == 8'hE0) begin
                    ext <= 1'b1;
                end else if (data_sr == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (code != 16'd0) begin
                        if (brk) begin
                            if (code == out) begin
                                out        <= 16'd0;
                                key_strobe <= 1'b1;
                            end
                        end else if (code != out) begin
                            out        <= code;
                            key_strobe <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
